// File: rtl/cost_table_feeder.sv
// cost_table_feeder: holds an 8x8 table of 7-bit costs for a downstream
// assignment search engine, sequences the engine's reset around table loads,
// and captures its result.
// Optional feature: define COST_LOWER_BOUND_EN to compute LowerBound, the sum
// of the per-worker minimum costs; otherwise LowerBound is tied to 0.
//
// state | meaning
// ------+------------------------------------------------------------------
// LOAD  | accepting 64 row-major cost words, engine held in reset
// RUN   | table complete, engine released, waiting for its result strobe
// DONE  | result captured and held, engine back in reset until Reload
module cost_table_feeder (
  input  logic       CLK,
  input  logic       RST,
  input  logic       InValid,
  input  logic [6:0] InData,
  output logic       InReady,
  input  logic       Reload,
  input  logic [2:0] W,
  input  logic [2:0] J,
  output logic [6:0] Cost,
  output logic       JamRst,
  input  logic       JamValid,
  input  logic [9:0] JamMinCost,
  input  logic [3:0] JamMatchCount,
  output logic       Done,
  output logic [9:0] ResMinCost,
  output logic [3:0] ResMatchCount,
  output logic [9:0] LowerBound
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] wcnt_q;
  logic [6:0] table_q [64];
  logic       jam_rst_q;
  logic [9:0] res_min_q;
  logic [3:0] res_cnt_q;
  logic       accept;
  logic       capture;

  // Reload outranks everything, so a coincident word or strobe is dropped.
  assign accept  = (state_q == LOAD) && InValid && !Reload;
  assign capture = (state_q == RUN) && JamValid && !Reload;

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    InReady = 1'b0;
    Done    = 1'b0;
    case (state_q)
      LOAD: begin
        InReady = 1'b1;
        if (accept && (wcnt_q == 6'd63)) state_d = RUN;
      end
      RUN: begin
        if (capture) state_d = DONE;
      end
      DONE: begin
        Done = 1'b1;
      end
      default: state_d = LOAD;
    endcase
    if (Reload) state_d = LOAD;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Engine reset is released only from the second RUN cycle onward, so the
  // engine sees one full cycle of the finished table before it starts; it
  // reasserts on the same edge that leaves RUN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) jam_rst_q <= 1'b1;
    else     jam_rst_q <= !((state_q == RUN) && (state_d == RUN));
  end

  assign JamRst = jam_rst_q;

  // Row-major word counter; wraps to 0 on the 64th word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         wcnt_q <= '0;
    else if (Reload) wcnt_q <= '0;
    else if (accept) wcnt_q <= wcnt_q + 6'd1;
  end

  // Cost table; Reload leaves old entries in place until overwritten.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 64; i++) table_q[i] <= '0;
    end else if (accept) begin
      table_q[wcnt_q] <= InData;
    end
  end

  assign Cost = table_q[{W, J}];

  // Result capture from the search engine.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_min_q <= '0;
      res_cnt_q <= '0;
    end else if (Reload) begin
      res_min_q <= '0;
      res_cnt_q <= '0;
    end else if (capture) begin
      res_min_q <= JamMinCost;
      res_cnt_q <= JamMatchCount;
    end
  end

  assign ResMinCost    = res_min_q;
  assign ResMatchCount = res_cnt_q;

`ifdef COST_LOWER_BOUND_EN
  logic [6:0] row_min_q;
  logic [6:0] row_min_new;
  logic [9:0] lb_q;

  // Running minimum of the current row; job 0 restarts it.
  always_comb begin
    row_min_new = InData;
    if ((wcnt_q[2:0] != 3'd0) && (row_min_q < InData)) row_min_new = row_min_q;
  end

  // Fold each row's minimum into the bound at the row's last word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_min_q <= '0;
      lb_q      <= '0;
    end else if (Reload) begin
      lb_q <= '0;
    end else if (accept) begin
      row_min_q <= row_min_new;
      if (wcnt_q[2:0] == 3'd7) lb_q <= lb_q + {3'b000, row_min_new};
    end
  end

  assign LowerBound = lb_q;
`else
  assign LowerBound = '0;
`endif

endmodule

// File: tb/tb_cost_table_feeder.sv
// Self-checking bench for cost_table_feeder: table loads (continuous and
// gapped), engine reset sequencing, result capture, Reload and async reset.
module tb_cost_table_feeder;

  logic       CLK;
  logic       RST;
  logic       InValid;
  logic [6:0] InData;
  logic       InReady;
  logic       Reload;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       JamRst;
  logic       JamValid;
  logic [9:0] JamMinCost;
  logic [3:0] JamMatchCount;
  logic       Done;
  logic [9:0] ResMinCost;
  logic [3:0] ResMatchCount;
  logic [9:0] LowerBound;

`ifdef COST_LOWER_BOUND_EN
  localparam int LB_INC = 8;
  localparam int LB_TOG = 28;
`else
  localparam int LB_INC = 0;
  localparam int LB_TOG = 0;
`endif

  int         checks = 0;
  int         passed = 0;
  int         exp_q[$];
  logic [6:0] model [64];

  cost_table_feeder dut (
    .CLK(CLK), .RST(RST), .InValid(InValid), .InData(InData), .InReady(InReady),
    .Reload(Reload), .W(W), .J(J), .Cost(Cost), .JamRst(JamRst),
    .JamValid(JamValid), .JamMinCost(JamMinCost), .JamMatchCount(JamMatchCount),
    .Done(Done), .ResMinCost(ResMinCost), .ResMatchCount(ResMatchCount),
    .LowerBound(LowerBound)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected table entries queued from the model, popped against Cost.
  task automatic check_table(input string tag);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(int'(model[i]));
      W = 3'(i / 8);
      J = 3'(i % 8);
      #1;
      chk(tag, int'(Cost), exp_q.pop_front());
    end
  endtask

  task automatic check_entry(input string tag, input int w, input int j);
    exp_q.push_back(int'(model[w * 8 + j]));
    W = 3'(w);
    J = 3'(j);
    #1;
    chk(tag, int'(Cost), exp_q.pop_front());
  endtask

  function automatic logic [6:0] row_word(input int a);
    int r;
    r = a / 8;
    return (a % 8 == 0) ? 7'(r) : 7'(10 + r);
  endfunction

  initial begin
    int a;
    int cyc;
    int n;
    RST = 1'b1; InValid = 1'b0; InData = '0; Reload = 1'b0; W = '0; J = '0;
    JamValid = 1'b0; JamMinCost = '0; JamMatchCount = '0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_inready", int'(InReady), 1);
    chk("rst_jamrst", int'(JamRst), 1);
    chk("rst_done", int'(Done), 0);
    chk("rst_resmin", int'(ResMinCost), 0);
    chk("rst_rescnt", int'(ResMatchCount), 0);
    chk("rst_lb", int'(LowerBound), 0);
    check_entry("rst_cost", 7, 7);
    RST = 1'b0;
    tick();

    // Continuous load, k%8+1.
    for (int k = 0; k < 64; k++) begin
      InValid = 1'b1;
      InData  = 7'(k % 8 + 1);
      model[k] = 7'(k % 8 + 1);
      if (k == 63) chk("inready_last", int'(InReady), 1);
      tick();
    end
    InValid = 1'b0;
    chk("run_inready", int'(InReady), 0);
    chk("run_jamrst_first", int'(JamRst), 1);
    chk("run_lb", int'(LowerBound), LB_INC);
    tick();
    chk("run_jamrst", int'(JamRst), 0);
    check_entry("cost_w3j5", 3, 5);
    chk("cost_w3j5_const", int'(Cost), 6);

    // Result capture.
    JamValid = 1'b1; JamMinCost = 10'd300; JamMatchCount = 4'd2;
    exp_q.push_back(300);
    exp_q.push_back(2);
    tick();
    JamValid = 1'b0;
    for (n = 0; n < 20 && !Done; n++) tick();
    chk("done_latency", n, 0);
    chk("done", int'(Done), 1);
    chk("res_min", int'(ResMinCost), exp_q.pop_front());
    chk("res_cnt", int'(ResMatchCount), exp_q.pop_front());
    chk("done_jamrst", int'(JamRst), 1);
    JamValid = 1'b1; JamMinCost = 10'd77; JamMatchCount = 4'd5;
    exp_q.push_back(300);
    exp_q.push_back(2);
    tick();
    JamValid = 1'b0;
    tick();
    chk("res_min_hold", int'(ResMinCost), exp_q.pop_front());
    chk("res_cnt_hold", int'(ResMatchCount), exp_q.pop_front());
    chk("done_hold", int'(Done), 1);
    chk("done_jamrst_hold", int'(JamRst), 1);

    // Reload, then gapped load with a stray JamValid during LOAD.
    Reload = 1'b1;
    tick();
    Reload = 1'b0;
    chk("rl_inready", int'(InReady), 1);
    chk("rl_done", int'(Done), 0);
    chk("rl_resmin", int'(ResMinCost), 0);
    chk("rl_rescnt", int'(ResMatchCount), 0);
    chk("rl_lb", int'(LowerBound), 0);
    chk("rl_jamrst", int'(JamRst), 1);
    a = 0;
    cyc = 0;
    while (a < 64 && cyc < 400) begin
      InValid  = (cyc % 2 == 0);
      InData   = InValid ? row_word(a) : 7'd127;
      JamValid = (cyc == 5);
      tick();
      if (InValid) begin
        model[a] = row_word(a);
        a++;
      end
      cyc++;
    end
    InValid = 1'b0;
    JamValid = 1'b0;
    chk("tog_accepted", a, 64);
    chk("tog_inready", int'(InReady), 0);
    chk("tog_done", int'(Done), 0);
    chk("tog_lb", int'(LowerBound), LB_TOG);
    InValid = 1'b1; InData = 7'd99;
    tick();
    InValid = 1'b0;
    check_table("tbl_toggle");

    // Reload coincident with word 10.
    Reload = 1'b1;
    tick();
    Reload = 1'b0;
    for (int k = 0; k < 10; k++) begin
      InValid = 1'b1;
      InData  = 7'(100 + k);
      model[k] = 7'(100 + k);
      tick();
    end
    InValid = 1'b1; InData = 7'd120; Reload = 1'b1;
    tick();
    InValid = 1'b0; Reload = 1'b0;
    chk("rl10_inready", int'(InReady), 1);
    chk("rl10_done", int'(Done), 0);
    chk("rl10_lb", int'(LowerBound), 0);
    check_table("tbl_reload");
    InValid = 1'b1; InData = 7'd55; model[0] = 7'd55;
    tick();
    InValid = 1'b0;
    check_entry("rl10_cnt0", 0, 0);
    check_entry("rl10_entry1", 0, 1);

    // Async reset while loading word 40.
    for (int k = 1; k < 40; k++) begin
      InValid = 1'b1;
      InData  = 7'(k);
      tick();
    end
    InValid = 1'b1; InData = 7'd33;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) model[i] = '0;
    chk("arst_inready", int'(InReady), 1);
    chk("arst_jamrst", int'(JamRst), 1);
    chk("arst_done", int'(Done), 0);
    chk("arst_resmin", int'(ResMinCost), 0);
    chk("arst_rescnt", int'(ResMatchCount), 0);
    chk("arst_lb", int'(LowerBound), 0);
    check_table("tbl_arst");
    InValid = 1'b0;
    RST = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cost_table_feeder.md
COST_TABLE_FEEDER -- requirements
Module: cost_table_feeder

Interface
REQ-001 SHALL have no parameters; the table is fixed at 8 workers x 8 jobs, 7-bit costs.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port InValid  input  1  load word valid.
REQ-005 SHALL have port InData  input  7  cost word; words arrive row-major, word k is worker k/8, job k%8.
REQ-006 SHALL have port InReady  output  1  feeder accepts a load word this cycle.
REQ-007 SHALL have port Reload  input  1  single-cycle request to discard results and reload the table.
REQ-008 SHALL have port W  input  3  worker index from the downstream search engine.
REQ-009 SHALL have port J  input  3  job index from the downstream search engine.
REQ-010 SHALL have port Cost  output  7  table[W][J], combinational, same cycle.
REQ-011 SHALL have port JamRst  output  1  registered active-high reset to the search engine.
REQ-012 SHALL have port JamValid  input  1  search engine result strobe.
REQ-013 SHALL have port JamMinCost  input  10  search engine minimum cost.
REQ-014 SHALL have port JamMatchCount  input  4  search engine count of minimum-cost assignments.
REQ-015 SHALL have port Done  output  1  result captured; held until Reload or RST.
REQ-016 SHALL have port ResMinCost  output  10  captured JamMinCost.
REQ-017 SHALL have port ResMatchCount  output  4  captured JamMatchCount.
REQ-018 SHALL have port LowerBound  output  10  sum of per-worker minimum costs (see Configuration).

Function
REQ-019 SHALL implement three states: LOAD, RUN and DONE.
REQ-020 In LOAD: InReady=1, JamRst=1; each cycle with InValid=1 SHALL write InData to the entry at a 6-bit word counter and increment the counter.
REQ-021 The 64th accepted word (counter 63) SHALL move the state to RUN on the same edge; JamRst SHALL read 0 from the next cycle; the counter SHALL wrap to 0.
REQ-022 In RUN: InReady=0, JamRst=0, InValid ignored; a JamValid=1 sample SHALL capture JamMinCost/JamMatchCount into ResMinCost/ResMatchCount and move to DONE; Done=1 from the next cycle.
REQ-023 In DONE: InReady=0, JamRst=1 (engine held in reset), further JamValid ignored, Res* outputs stable.
REQ-024 Reload=1 in any state SHALL on that edge enter LOAD, clear the counter, Done, ResMinCost, ResMatchCount and LowerBound; table contents SHALL be retained until overwritten.
REQ-025 Reload and InValid in the same LOAD cycle: Reload wins, the word is discarded and not counted.
REQ-026 Cost SHALL reflect table[W][J] in every state, including stale or partially loaded entries during LOAD.
REQ-027 JamValid in LOAD SHALL be ignored.

Reset
REQ-028 RST SHALL asynchronously force: state LOAD, counter 0, all 64 table entries 0, InReady=1, JamRst=1, Done=0, ResMinCost=0, ResMatchCount=0, LowerBound=0.

Configuration
REQ-029 With macro COST_LOWER_BOUND_EN defined, the feeder SHALL track a running minimum over each group of 8 words and add it to LowerBound at the 8th word of each row; LowerBound is final when RUN is entered (max 8x127=1016, no overflow).
REQ-030 Without COST_LOWER_BOUND_EN, LowerBound SHALL be constant 0 and the minimum-tracking logic SHALL be absent.

Verification
REQ-031 RST, then 64 words InData=k%8+1 with InValid held high -> RUN after 64 cycles; JamRst falls one cycle later; W=3,J=5 gives Cost=6.
REQ-032 Load with InValid toggled every other cycle -> exactly 64 words accepted; entries match the order of accepted words, with no gaps.
REQ-033 In RUN, JamValid=1 with JamMinCost=300 and JamMatchCount=2 -> Done=1, ResMinCost=300, ResMatchCount=2 next cycle; JamRst=1; a second JamValid pulse leaves the results unchanged.
REQ-034 Reload coincident with word 10 in LOAD -> word discarded, counter 0, InReady=1, Done=0, old table still readable via W/J.
REQ-035 COST_LOWER_BOUND_EN, row r words all 10+r except job 0 = r -> LowerBound=28 in RUN; without the macro -> LowerBound=0.
REQ-036 RST asserted mid-LOAD at word 40 -> all outputs at reset values immediately and Cost=0 for every W/J.
